// File: rtl/vad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vad_pkg
//  Description : Shared types and constants for the voice activity detector:
//                hysteresis state encoding, display digit ceiling and the
//                accumulator width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vad_pkg;

    // Hysteresis states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        SILENT   = 2'd0,
        ONSET    = 2'd1,
        ACTIVE   = 2'd2,
        HANGOVER = 2'd3
    } vad_state_t;

    // Largest value the 7-segment loudness digit may show
    localparam int LEVEL_MAX = 9;

    // Window sum width: one extra bit per doubling of the window length
    function automatic int ACC_W(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

endpackage : vad_pkg
`default_nettype wire

// File: rtl/vad_window_accum.sv
`default_nettype none
// ============================================================================
//  Module      : vad_window_accum
//  Description : Saturating absolute value, windowed sum of |x|, sample
//                counter, window-end strobe and registered window mean.
//                Optional peak-hold of |x| when VAD_PEAK_HOLD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module vad_window_accum
    import vad_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_win_end,
    output logic [DATA_W-1:0] o_win_mean,
    output logic [DATA_W-1:0] o_env_level,
    output logic              o_env_valid,
    output logic [DATA_W-1:0] o_peak_abs
);

    localparam int                c_ACC_W   = ACC_W(DATA_W, WIN_LOG2);
    localparam logic [DATA_W-1:0] c_MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [WIN_LOG2-1:0] c_LAST  = '1;

    logic [DATA_W-1:0]   w_abs;
    logic [c_ACC_W-1:0]  w_sum_next;
    logic                w_win_end;
    logic [c_ACC_W-1:0]  r_sum;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [DATA_W-1:0]   r_env_level;
    logic                r_env_valid;

    // Magnitude of the signed sample; the most negative code clamps to max positive
    always_comb begin
        w_abs = i_data;
        if (i_data[DATA_W-1]) begin
            w_abs = (i_data == c_MIN_NEG) ? c_MAX_POS : (~i_data + 1'b1);
        end
    end

    assign w_sum_next = r_sum + {{WIN_LOG2{1'b0}}, w_abs};
    assign w_win_end  = i_sample_en && (r_cnt == c_LAST);
    assign o_win_end  = w_win_end;
    // Dividing by the window length is a plain drop of the low bits
    assign o_win_mean = w_sum_next[c_ACC_W-1:WIN_LOG2];

    // Sum and counter restart on the window's last sample so the next one is kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_sample_en) begin
            if (w_win_end) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else begin
                r_sum <= w_sum_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Publish the window mean one cycle after the closing sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_env_level <= '0;
            r_env_valid <= 1'b0;
        end else begin
            r_env_valid <= w_win_end;
            if (w_win_end) begin
                r_env_level <= o_win_mean;
            end
        end
    end

    assign o_env_level = r_env_level;
    assign o_env_valid = r_env_valid;

`ifdef VAD_PEAK_HOLD_EN
    logic [DATA_W-1:0] r_peak_run;
    logic [DATA_W-1:0] r_peak_abs;
    logic [DATA_W-1:0] w_peak_next;

    assign w_peak_next = (w_abs > r_peak_run) ? w_abs : r_peak_run;

    // Running max over the window, latched and cleared at window end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak_run <= '0;
            r_peak_abs <= '0;
        end else if (i_sample_en) begin
            if (w_win_end) begin
                r_peak_abs <= w_peak_next;
                r_peak_run <= '0;
            end else begin
                r_peak_run <= w_peak_next;
            end
        end
    end

    assign o_peak_abs = r_peak_abs;
`else
    assign o_peak_abs = '0;
`endif

endmodule : vad_window_accum
`default_nettype wire

// File: rtl/voice_activity_detector.sv
`default_nettype none
// ============================================================================
//  Module      : voice_activity_detector
//  Description : Windowed mean-absolute envelope of the filtered sample
//                stream, hysteresis speech detector and 0..9 loudness digit.
//                Define VAD_PEAK_HOLD_EN to build the per-window |x| peak
//                output; otherwise peak_abs is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_activity_detector
    import vad_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                WIN_LOG2    = 6,
    parameter logic [DATA_W-1:0] ON_THRESH   = 4096,
    parameter logic [DATA_W-1:0] OFF_THRESH  = 2048,
    parameter int                ONSET_WINS  = 2,
    parameter int                HANG_WINS   = 4,
    parameter int                LEVEL_SHIFT = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] filtered_data,
    output logic [DATA_W-1:0] env_level,
    output logic              env_valid,
    output logic              voice_active,
    output logic              voice_start,
    output logic [3:0]        level_digit,
    output logic [DATA_W-1:0] peak_abs
);

    localparam int c_CNT_MAX = (ONSET_WINS > HANG_WINS) ? ONSET_WINS : HANG_WINS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT    = '1;
    localparam logic [c_CNT_W-1:0] c_ONSET_WINS = c_CNT_W'(ONSET_WINS);
    localparam logic [c_CNT_W-1:0] c_HANG_WINS  = c_CNT_W'(HANG_WINS);
    localparam logic [DATA_W-1:0]  c_LEVEL_MAX  = DATA_W'(LEVEL_MAX);

    logic              w_win_end;
    logic [DATA_W-1:0] w_win_mean;
    logic              w_loud;
    logic              w_quiet;
    logic [DATA_W-1:0] w_shifted;
    logic [3:0]        w_digit;

    vad_state_t         r_state;
    vad_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_start;
    logic               r_voice_start;
    logic [3:0]         r_level_digit;

    vad_window_accum #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .clk         (clk),
        .reset       (reset),
        .i_sample_en (sample_en),
        .i_data      (filtered_data),
        .o_win_end   (w_win_end),
        .o_win_mean  (w_win_mean),
        .o_env_level (env_level),
        .o_env_valid (env_valid),
        .o_peak_abs  (peak_abs)
    );

    assign w_loud    = (w_win_mean >= ON_THRESH);
    assign w_quiet   = (w_win_mean <  OFF_THRESH);
    assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;

    // Quantise the new mean to the display digit, clamped at LEVEL_MAX
    assign w_shifted = w_win_mean >> LEVEL_SHIFT;
    assign w_digit   = (w_shifted > c_LEVEL_MAX) ? 4'(LEVEL_MAX) : w_shifted[3:0];

    // Hysteresis next-state; only a completed window may move the state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        if (w_win_end) begin
            case (r_state)
                SILENT: begin
                    if (w_loud) begin
                        if (ONSET_WINS == 1) begin
                            w_state_next = ACTIVE;
                            w_cnt_next   = '0;
                            w_start      = 1'b1;
                        end else begin
                            w_state_next = ONSET;
                            w_cnt_next   = c_CNT_W'(1);
                        end
                    end
                end
                ONSET: begin
                    if (w_loud) begin
                        if (w_cnt_inc >= c_ONSET_WINS) begin
                            w_state_next = ACTIVE;
                            w_cnt_next   = '0;
                            w_start      = 1'b1;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = SILENT;
                        w_cnt_next   = '0;
                    end
                end
                ACTIVE: begin
                    if (w_quiet) begin
                        if (HANG_WINS > 1) begin
                            w_state_next = HANGOVER;
                            w_cnt_next   = c_CNT_W'(1);
                        end else begin
                            w_state_next = SILENT;
                            w_cnt_next   = '0;
                        end
                    end
                end
                HANGOVER: begin
                    if (w_loud) begin
                        w_state_next = ACTIVE;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc >= c_HANG_WINS) begin
                        w_state_next = SILENT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = SILENT;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // State, window counter, start pulse and digit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= SILENT;
            r_cnt         <= '0;
            r_voice_start <= 1'b0;
            r_level_digit <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_voice_start <= w_start;
            if (w_win_end) begin
                r_level_digit <= w_digit;
            end
        end
    end

    assign voice_active = (r_state == ACTIVE) || (r_state == HANGOVER);
    assign voice_start  = r_voice_start;
    assign level_digit  = r_level_digit;

endmodule : voice_activity_detector
`default_nettype wire

// File: tb/tb_voice_activity_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_activity_detector
//  Description : Self-checking bench for voice_activity_detector with a
//                4-sample window, hand-computed window table, reset and
//                peak corner sequences and a randomized model comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_activity_detector;

    localparam int     WIN     = 4;
    localparam longint ON_T    = 1000;
    localparam longint OFF_T   = 500;
    localparam int     ONSET_N = 2;
    localparam int     HANG_N  = 2;
    localparam longint DIV_LVL = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_en = 1'b0;
    logic [31:0] filtered_data = '0;
    logic [31:0] env_level;
    logic        env_valid;
    logic        voice_active;
    logic        voice_start;
    logic [3:0]  level_digit;
    logic [31:0] peak_abs;

    int checks = 0;
    int errors = 0;

    voice_activity_detector #(
        .DATA_W      (32),
        .WIN_LOG2    (2),
        .ON_THRESH   (32'd1000),
        .OFF_THRESH  (32'd500),
        .ONSET_WINS  (2),
        .HANG_WINS   (2),
        .LEVEL_SHIFT (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .filtered_data (filtered_data),
        .env_level     (env_level),
        .env_valid     (env_valid),
        .voice_active  (voice_active),
        .voice_start   (voice_start),
        .level_digit   (level_digit),
        .peak_abs      (peak_abs)
    );

    always #5 clk = ~clk;

    // Reference model: windows as plain sums, speech as loud/quiet streaks
    longint m_sum, m_peak;
    int     m_n;
    bit     m_voice;
    int     m_loud_run, m_hang;
    bit     e_done, e_start;
    longint e_level, e_digit, e_peak;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sum = 0; m_peak = 0; m_n = 0;
        m_voice = 0; m_loud_run = 0; m_hang = 0;
        e_done = 0; e_start = 0;
    endtask

    task automatic model_step(input logic [31:0] x);
        longint v, a;
        bit loud, quiet;
        v = longint'($signed(x));
        if (v < 0) a = (v == -64'sd2147483648) ? 64'sd2147483647 : -v;
        else       a = v;
        m_sum += a;
        if (a > m_peak) m_peak = a;
        m_n++;
        e_done = 0; e_start = 0;
        if (m_n == WIN) begin
            e_done  = 1;
            e_level = m_sum / WIN;
            e_digit = (e_level / DIV_LVL > 9) ? 9 : e_level / DIV_LVL;
            e_peak  = m_peak;
            m_sum = 0; m_n = 0; m_peak = 0;
            loud  = (e_level >= ON_T);
            quiet = (e_level < OFF_T);
            if (!m_voice) begin
                if (loud) begin
                    m_loud_run++;
                    if (m_loud_run >= ONSET_N) begin
                        m_voice = 1; e_start = 1; m_loud_run = 0; m_hang = 0;
                    end
                end else m_loud_run = 0;
            end else if (m_hang == 0) begin
                if (quiet) begin
                    m_hang = 1;
                    if (m_hang >= HANG_N) begin m_voice = 0; m_hang = 0; end
                end
            end else begin
                if (loud) m_hang = 0;
                else begin
                    m_hang++;
                    if (m_hang >= HANG_N) begin m_voice = 0; m_hang = 0; end
                end
            end
        end
    endtask

    // One accepted sample; outputs checked 1 time unit after the capturing edge
    task automatic apply_sample(input logic [31:0] x);
        @(negedge clk);
        sample_en = 1'b1;
        filtered_data = x;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        model_step(x);
        check("env_valid", env_valid, e_done);
        check("voice_active", voice_active, m_voice);
        check("voice_start", voice_start, e_start);
        if (e_done) begin
            check("env_level", env_level, e_level);
            check("level_digit", level_digit, e_digit);
`ifdef VAD_PEAK_HOLD_EN
            check("peak_abs", peak_abs, e_peak);
`else
            check("peak_abs", peak_abs, 0);
`endif
        end
    endtask

    task automatic idle();
        @(negedge clk);
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        check("idle_env_valid", env_valid, 0);
        check("idle_voice_start", voice_start, 0);
        check("idle_voice_active", voice_active, m_voice);
    endtask

    task automatic apply_window(input logic [31:0] s);
        for (int k = 0; k < WIN; k++) apply_sample((k % 2) ? -s : s);
    endtask

    typedef struct {
        logic [31:0] sample;
        logic [31:0] exp_level;
        logic [3:0]  exp_digit;
        logic        exp_active;
        logic        exp_start;
    } win_vec_t;

    win_vec_t vecs[10];

    initial begin
        logic [31:0] s;
        int base;

        vecs[0] = '{32'd1200, 32'd1200, 4'd9, 1'b0, 1'b0};
        vecs[1] = '{32'd1200, 32'd1200, 4'd9, 1'b1, 1'b1};
        vecs[2] = '{32'd700,  32'd700,  4'd5, 1'b1, 1'b0};
        vecs[3] = '{32'd500,  32'd500,  4'd3, 1'b1, 1'b0};
        vecs[4] = '{32'd100,  32'd100,  4'd0, 1'b1, 1'b0};
        vecs[5] = '{32'd1000, 32'd1000, 4'd7, 1'b1, 1'b0};
        vecs[6] = '{32'd100,  32'd100,  4'd0, 1'b1, 1'b0};
        vecs[7] = '{32'd100,  32'd100,  4'd0, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 4'd9, 1'b0, 1'b0};
        vecs[9] = '{32'd0,    32'd0,    4'd0, 1'b0, 1'b0};

        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_env_level", env_level, 0);
        check("rst_env_valid", env_valid, 0);
        check("rst_voice_active", voice_active, 0);
        check("rst_voice_start", voice_start, 0);
        check("rst_level_digit", level_digit, 0);
        check("rst_peak_abs", peak_abs, 0);
        @(negedge clk);
        reset = 1'b1;

        // Hand-computed window table: onset, hold, hangover, boundaries, saturation
        for (int i = 0; i < 10; i++) begin
            apply_window(vecs[i].sample);
            check($sformatf("tbl%0d_level", i), env_level, vecs[i].exp_level);
            check($sformatf("tbl%0d_digit", i), level_digit, vecs[i].exp_digit);
            check($sformatf("tbl%0d_active", i), voice_active, vecs[i].exp_active);
            check($sformatf("tbl%0d_start", i), voice_start, vecs[i].exp_start);
            idle();
        end

        // Asynchronous reset mid-window with sample_en toggling
        apply_window(32'd1200);
        apply_sample(32'd300);
        idle();
        apply_sample(-32'd300);
        idle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_env_level", env_level, 0);
        check("arst_env_valid", env_valid, 0);
        check("arst_voice_active", voice_active, 0);
        check("arst_level_digit", level_digit, 0);
        check("arst_peak_abs", peak_abs, 0);
        model_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < WIN; k++) begin
            apply_sample((k % 2) ? -32'd400 : 32'd400);
            check("fresh_valid_after", env_valid, (k == WIN - 1));
            idle();
        end
        check("fresh_level", env_level, 400);

        // Peak window
        apply_sample(32'd10);
        apply_sample(-32'd300);
        apply_sample(32'd20);
        apply_sample(32'd5);
        check("peak_env_level", env_level, 83);
`ifdef VAD_PEAK_HOLD_EN
        check("peak_value", peak_abs, 300);
`else
        check("peak_value", peak_abs, 0);
`endif
        idle();

        // Randomized windows against the model
        for (int w = 0; w < 40; w++) begin
            case ($urandom_range(0, 4))
                0: base = 100;
                1: base = 600;
                2: base = 1100;
                3: base = 2000;
                default: base = int'($urandom_range(0, 3000));
            endcase
            for (int k = 0; k < WIN; k++) begin
                if ($urandom_range(0, 19) == 0) s = 32'h8000_0000;
                else begin
                    s = 32'(base + int'($urandom_range(0, 200)) - 100);
                    if ($urandom_range(0, 1) == 1) s = -s;
                end
                apply_sample(s);
                if ($urandom_range(0, 2) == 0) idle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_voice_activity_detector
`default_nettype wire

// File: doc/voice_activity_detector.md
Name: voice_activity_detector

Overview:
- Sits directly downstream of the low-pass filter and consumes its 32-bit filtered sample stream.
- Each window it computes a mean-absolute-amplitude envelope over 2^WIN_LOG2 samples.
- A hysteresis state machine decides whether speech is present.
- Outputs are a voice-active flag, a start pulse, and a 0–9 loudness digit for the 7-segment driver.

Parameters:
- DATA_W, 32: sample width, two's complement.
- WIN_LOG2, 6: log2 of the window length (64 samples).
- ON_THRESH, 32'd4096: mean level at or above which a window counts as loud.
- OFF_THRESH, 32'd2048: mean level strictly below which a window counts as quiet. Must satisfy OFF_THRESH <= ON_THRESH.
- ONSET_WINS, 2: consecutive loud windows required to declare voice. Must be 1 or more.
- HANG_WINS, 4: consecutive non-loud windows tolerated before declaring silence. Must be 1 or more.
- LEVEL_SHIFT, 12: right shift from the mean to the display digit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- sample_en  in  1  qualifies filtered_data for one cycle.
- filtered_data  in  DATA_W  signed filtered sample.
- env_level  out  DATA_W  mean absolute amplitude of the last completed window.
- env_valid  out  1  one-cycle pulse when env_level updates.
- voice_active  out  1  high while in ACTIVE or HANGOVER.
- voice_start  out  1  one-cycle pulse on entry to ACTIVE from ONSET or SILENT.
- level_digit  out  4  min(9, env_level >> LEVEL_SHIFT), range 0..9.
- peak_abs  out  DATA_W  see Optional Feature.

Behaviour:
- Reset: all outputs 0, accumulator 0, sample counter 0, state SILENT, window counter 0. Reset is asynchronous and may assert mid-window; the partial window is discarded.
- Absolute value:
  - |x| computed combinationally.
  - -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - Unsigned thereafter.
- Accumulation:
  - On each cycle with sample_en=1, sum += |x| and the sample counter increments.
  - Sum width is DATA_W+WIN_LOG2, so no overflow is possible.
  - sample_en=0 holds all state.
- Window end (the accepted sample with counter = 2^WIN_LOG2-1):
  - Next cycle: env_level <= (sum + |x|) >> WIN_LOG2, env_valid=1, level_digit updates.
  - Sum and counter restart at 0 the same cycle, so no sample is lost.
  - Latency: 1 cycle from the last sample accepted.
- FSM evaluates only on the window-end cycle, using the new mean m. Loud means m >= ON_THRESH; quiet means m < OFF_THRESH.
  - SILENT:
    - Loud, ONSET_WINS=1: go to ACTIVE and pulse voice_start.
    - Loud, otherwise: go to ONSET with cnt=1.
  - ONSET:
    - Loud: cnt+1; on reaching ONSET_WINS go to ACTIVE and pulse voice_start.
    - Not loud: go to SILENT, cnt=0.
  - ACTIVE:
    - Quiet: go to HANGOVER with cnt=1 if HANG_WINS>1; go to SILENT if HANG_WINS=1.
    - Otherwise (including m between thresholds): stay.
  - HANGOVER:
    - Loud: go to ACTIVE with no voice_start pulse.
    - Otherwise: cnt+1; on reaching HANG_WINS go to SILENT.
- State-derived outputs:
  - voice_active and voice_start change in the same cycle as env_valid.
  - voice_start is high for exactly 1 cycle.
- Boundaries:
  - m == ON_THRESH counts as loud.
  - m == OFF_THRESH is not quiet.
  - Window counters saturate and never wrap.

Optional Feature:
- VAD_PEAK_HOLD_EN defined:
  - A running max of |x| is kept over the window.
  - peak_abs is registered alongside env_level at window end.
  - The running max restarts with the next window.
- VAD_PEAK_HOLD_EN undefined: peak_abs is tied to 0 and no peak logic is built.

Decomposition:
- Package vad_pkg holds:
  - the state enum (SILENT, ONSET, ACTIVE, HANGOVER);
  - the digit constant LEVEL_MAX=9;
  - the width helper ACC_W = DATA_W + WIN_LOG2.
- One sub-module, vad_window_accum, holds abs/saturate, sum, sample counter, window-end strobe and the optional peak logic.
- The FSM and digit quantiser stay in the top level.

Test Plan:
Bench overrides: WIN_LOG2=2, ON=1000, OFF=500, ONSET_WINS=2, HANG_WINS=2, LEVEL_SHIFT=7.
1. Feed 4 samples {1200,-1200,1200,-1200}, then 4 more.
   -> First env_valid: env_level=1200, level_digit=9, state ONSET, voice_active=0.
   -> Second window: voice_start pulses 1 cycle, voice_active=1.
2. In ACTIVE, feed windows of |x|=700.
   -> Stays ACTIVE (between thresholds).
   -> Then 2 windows of 100: HANGOVER, then SILENT with voice_active=0 after the 2nd window.
3. In HANGOVER, feed one window at 1000.
   -> Returns to ACTIVE with no voice_start pulse.
4. Sample -2147483648 ×4 (bench DATA_W=32).
   -> env_level=2147483647, no overflow.
5. Toggle sample_en every other cycle, with reset pulled low after 2 samples.
   -> All outputs 0 immediately.
   -> After release, env_valid occurs only after 4 fresh accepted samples.
6. VAD_PEAK_HOLD_EN defined, feed {10,-300,20,5}.
   -> peak_abs=300, env_level=83.
   -> With the macro undefined, peak_abs=0.
